lfsr_gen_param: RTL
===================

# lfsr_gen_param

Parametrised Galois LFSR pseudo-random word generator with a programmable polynomial, seed load, decimation (STEPS advances per output word) and a valid/ready output handshake. It also counts delivered words and flags when the sequence returns to its seed. It is the generalised successor of the fixed 8-bit generator and feeds scramblers, test-pattern sources and randomised arbiters in the same design.

## Interface
- WIDTH, 8: LFSR and output width; must be ≥ 2.
- TAPS, 8'h71: Galois feedback mask; bit i set means bit i is XORed with the old MSB. The default is x^8+x^6+x^5+x^4+1, period 255.
- DEFAULT_SEED, 8'h01: state after reset; must be nonzero.
- STEPS, 1: LFSR advances per output word; must be ≥ 1.
- CNT_W, 16: width of word_cnt.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level; run generation while high.
- load  in  1  load seed (one-cycle pulse).
- seed  in  WIDTH  seed value, sampled when load=1.
- out_data  out  WIDTH  generated word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- busy  out  1  FSM not in IDLE.
- period  out  1  one-cycle pulse: an advance produced state == seed_reg.
- word_cnt  out  CNT_W  accepted words since reset/load; wraps to 0.
- seed_fixed  out  1  one-cycle pulse: zero seed replaced (macro only).

## Operation
- Advance rule: state ← {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? TAPS : 0).
- seed_reg holds the most recently loaded seed, or DEFAULT_SEED after reset.
- FSM states: IDLE, STEP, WAIT.
  - IDLE: en=1 → STEP; step counter ← STEPS.
  - STEP: advance once per cycle. On the STEPS-th advance: out_data ← new state, out_valid ← 1, go to WAIT. Deasserting en in STEP does not abort the current word.
  - WAIT: hold state and out_data. On out_valid&&out_ready: out_valid ← 0, word_cnt += 1 (mod 2^CNT_W), then go to STEP if en=1 (counter ← STEPS), else IDLE.
- Load: priority below rst, above everything else, in any FSM state.
  - state ← seed and seed_reg ← seed.
  - out_valid ← 0; any pending word is discarded.
  - word_cnt ← 0; FSM → IDLE.
  - The load edge does not advance the LFSR. en is ignored on the load edge.
- period: asserted the cycle after any advance whose result equals seed_reg. It is independent of the handshake.
- Reset values:
  - state = seed_reg = DEFAULT_SEED; FSM = IDLE.
  - out_data = 0, out_valid = 0, busy = 0, period = 0, word_cnt = 0, seed_fixed = 0.

## Timing
- Latency: out_valid rises STEPS cycles after the edge that samples en=1 in IDLE.
- Throughput: one word per STEPS+1 cycles when out_ready is held high. The handshake cycle is not a step cycle.
- out_data is stable whenever out_valid=1 and out_ready=0, for any stall length.
- out_ready while out_valid=0 has no effect.
- rst during any state overrides load, en and the handshake. Outputs return to reset values on the next edge.
- load in the same cycle as a valid&&ready handshake: load wins; word_cnt ← 0, not incremented.

## Configuration
- LFSR_GEN_ZERO_SEED_GUARD_EN
  - Defined: load with seed=0 stores DEFAULT_SEED into state and seed_reg, and pulses seed_fixed for one cycle. Zero state is unreachable.
  - Undefined: a zero seed is loaded verbatim. The generator then emits 0 forever, and period pulses on every advance. seed_fixed is tied to 0.

## Test plan
- Reset → en=1, out_ready=1, STEPS=1, default params: out_data sequence 0x02, 0x04, 0x08, …, 0x80, 0x71, 0xE2, 0xB5; word_cnt increments per word.
- STEPS=3, load seed=0x01, en=1: words are 0x08, 0x40, 0xE2; out_valid rises 3 cycles after en is sampled.
- Hold out_ready=0 for 10 cycles with out_valid=1: out_data is unchanged and the LFSR does not advance. Then out_ready=1: exactly one word is accepted.
- Load 0x01, run 255 advances: period pulses exactly once, on the 255th advance.
- Load asserted mid-WAIT while a handshake occurs: out_valid=0, word_cnt=0, FSM=IDLE, state=new seed.
- load seed=0x00: with the macro, state=0x01 and seed_fixed pulses; without it, the first word is 0x00 and period pulses every advance.

Source files
------------

// File: rtl/lfsr_gen_param_if.sv
// ---------------------------------------------------------------------------
// lfsr_gen_param_if
//
// Purpose: output word channel of the LFSR generator. It carries one
// generated word together with its valid/ready handshake.
//
// Signals:
//    out_data   generated word, driven by the generator
//    out_valid  out_data holds a word that has not been accepted yet
//    out_ready  consumer accepts the word offered in this cycle
//
// Modports:
//    master  the generator side (drives data/valid, observes ready)
//    slave   the consumer side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface lfsr_gen_param_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/lfsr_gen_param.sv
// ---------------------------------------------------------------------------
// lfsr_gen_param
//
// Purpose: parametrised Galois LFSR pseudo-random word generator. The LFSR
// advances STEPS times per delivered word, the word is offered on a
// valid/ready channel, accepted words are counted, and a pulse marks every
// advance that brings the sequence back to the most recently loaded seed.
//
// Parameters:
//    WIDTH         LFSR and word width (>= 2)
//    TAPS          Galois feedback mask, bit i XORed with the old MSB
//    DEFAULT_SEED  LFSR state and seed register value after reset (nonzero)
//    STEPS         LFSR advances per output word (>= 1)
//    CNT_W         width of the accepted-word counter
//
// Ports:
//    clk         clock, everything on the rising edge
//    rst         synchronous active-high reset
//    en          level; keep generating words while high
//    load        one-cycle pulse; load seed into state and seed register
//    seed        seed value sampled when load is high
//    out_if      word channel (out_data, out_valid, out_ready), master side
//    busy        FSM is not idle
//    period      one-cycle pulse after an advance that produced the seed
//    word_cnt    accepted words since reset or load, wraps around
//    seed_fixed  one-cycle pulse when a zero seed was replaced
//
// Build option:
//    LFSR_GEN_ZERO_SEED_GUARD_EN  when defined, a zero seed is replaced by
//    DEFAULT_SEED on load and seed_fixed pulses; when undefined, a zero seed
//    is loaded as-is (the generator then locks at zero) and seed_fixed is 0.
// ---------------------------------------------------------------------------
module lfsr_gen_param #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] TAPS         = 8'h71,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01,
   parameter int               STEPS        = 1,
   parameter int               CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load,
   input  logic [WIDTH-1:0]     seed,
   lfsr_gen_param_if.master     out_if,
   output logic                 busy,
   output logic                 period,
   output logic [CNT_W-1:0]     word_cnt,
   output logic                 seed_fixed
);

   localparam int CW = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      WAIT
   } fsm_t;

   fsm_t             fsm_q,      fsm_d;
   logic [WIDTH-1:0] state_q,    state_d;
   logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
   logic [CW-1:0]    step_cnt_q, step_cnt_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             period_q,   period_d;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] adv_state;
`ifdef LFSR_GEN_ZERO_SEED_GUARD_EN
   logic             seed_fixed_q, seed_fixed_d;
`endif

   // One Galois step: shift left and fold the feedback taps in whenever the
   // bit shifted out of the top was set.
   function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
   endfunction

   assign adv_state = lfsr_advance(state_q);

   // Value that a load writes into the LFSR and the seed register. With the
   // guard built in, a zero seed would lock the LFSR at zero forever, so it is
   // swapped for the default seed and the swap is reported on seed_fixed.
   always_comb begin
      load_val = seed;
`ifdef LFSR_GEN_ZERO_SEED_GUARD_EN
      seed_fixed_d = 1'b0;
      if (seed == '0) begin
         load_val     = DEFAULT_SEED;
         seed_fixed_d = load;
      end
`endif
   end

   // Next-state logic of the generator. A load overrides whatever the FSM is
   // doing: it reseeds, drops any word still on offer, clears the counter and
   // parks the FSM in IDLE without advancing. Otherwise STEP advances once per
   // cycle until the programmed number of steps is done and the word is
   // offered; WAIT holds everything until the consumer takes the word. en is
   // only looked at when a new word is about to start, so dropping en in the
   // middle of a word still lets that word finish.
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      seed_reg_d  = seed_reg_q;
      step_cnt_d  = step_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      word_cnt_d  = word_cnt_q;
      period_d    = 1'b0;

      if (load) begin
         state_d     = load_val;
         seed_reg_d  = load_val;
         out_valid_d = 1'b0;
         word_cnt_d  = '0;
         fsm_d       = IDLE;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (en) begin
                  fsm_d      = STEP;
                  step_cnt_d = CW'(STEPS);
               end
            end
            STEP: begin
               state_d    = adv_state;
               period_d   = (adv_state == seed_reg_q);
               step_cnt_d = step_cnt_q - CW'(1);
               if (step_cnt_q == CW'(1)) begin
                  out_data_d  = adv_state;
                  out_valid_d = 1'b1;
                  fsm_d       = WAIT;
               end
            end
            WAIT: begin
               if (out_valid_q && out_if.out_ready) begin
                  out_valid_d = 1'b0;
                  word_cnt_d  = word_cnt_q + CNT_W'(1);
                  if (en) begin
                     fsm_d      = STEP;
                     step_cnt_d = CW'(STEPS);
                  end else begin
                     fsm_d = IDLE;
                  end
               end
            end
            default: begin
               fsm_d = IDLE;
            end
         endcase
      end
   end

   // State register. Reset brings back the default seed and clears every
   // output register; it wins over load, en and the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_q     <= DEFAULT_SEED;
         seed_reg_q  <= DEFAULT_SEED;
         step_cnt_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         word_cnt_q  <= '0;
         period_q    <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         seed_reg_q  <= seed_reg_d;
         step_cnt_q  <= step_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         word_cnt_q  <= word_cnt_d;
         period_q    <= period_d;
      end
   end

`ifdef LFSR_GEN_ZERO_SEED_GUARD_EN
   // Register for the zero-seed replacement pulse, so it appears in the cycle
   // after the load together with the new state.
   always_ff @(posedge clk) begin
      if (rst) begin
         seed_fixed_q <= 1'b0;
      end else begin
         seed_fixed_q <= seed_fixed_d;
      end
   end

   assign seed_fixed = seed_fixed_q;
`else
   assign seed_fixed = 1'b0;
`endif

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign busy             = (fsm_q != IDLE);
   assign period           = period_q;
   assign word_cnt         = word_cnt_q;

endmodule
